// File: rtl/gerenciador_contexto_pkg.sv
// Shared definitions for the LabSO context-switch executor: default sizes,
// FSM state encoding and the slot/register index width helper.
package gerenciador_contexto_pkg;

    localparam int NPROC_PADRAO = 8;
    localparam int NREGS_PADRAO = 32;
    localparam int DW_PADRAO    = 32;

    typedef enum logic [2:0] {
        IDLE,
        SALVA,
        RESTAURA,
        CARREGA_PC,
        CONCLUI
    } estado_t;

    // Width of an index into n entries; a single entry still needs one bit.
    function automatic int largura_slot(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gerenciador_contexto_if.sv
// Bundle of scheduler, process-creation, register-file and PC signals seen by
// the context-switch executor; slave is the executor, master is its environment.
interface gerenciador_contexto_if
    import gerenciador_contexto_pkg::*;
#(
    parameter int NPROC = NPROC_PADRAO,
    parameter int NREGS = NREGS_PADRAO,
    parameter int DW    = DW_PADRAO
);
    localparam int SW = largura_slot(NPROC);
    localparam int RW = largura_slot(NREGS);

    logic          troca_contexto;
    logic [DW-1:0] processo_atual;
    logic [DW-1:0] pc_processo_atual;
    logic          criar_processo;
    logic [SW-1:0] id_novo;
    logic [DW-1:0] pc_inicial;
    logic          cpu_stall;
    logic [RW-1:0] rf_addr;
    logic [DW-1:0] rf_rdata;
    logic          rf_we;
    logic [DW-1:0] rf_wdata;
    logic          pc_we;
    logic [DW-1:0] pc_novo;
    logic          troca_concluida;
    logic          erro_processo;
    logic [SW-1:0] id_executando;

    modport slave (
        input  troca_contexto, processo_atual, pc_processo_atual,
        input  criar_processo, id_novo, pc_inicial, rf_rdata,
        output cpu_stall, rf_addr, rf_we, rf_wdata, pc_we, pc_novo,
        output troca_concluida, erro_processo, id_executando
    );

    modport master (
        output troca_contexto, processo_atual, pc_processo_atual,
        output criar_processo, id_novo, pc_inicial, rf_rdata,
        input  cpu_stall, rf_addr, rf_we, rf_wdata, pc_we, pc_novo,
        input  troca_concluida, erro_processo, id_executando
    );

endinterface

// File: rtl/gerenciador_contexto_memoria.sv
// Per-process register context store: simple dual-port RAM, synchronous read,
// write-first on a same-address collision, no reset.
module memoria_contexto #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end

endmodule

// File: rtl/gerenciador_contexto.sv
// Context-switch executor: stalls the CPU, saves the outgoing register file and
// PC, restores the incoming process and releases the CPU. Also owns the process table.
module gerenciador_contexto
    import gerenciador_contexto_pkg::*;
#(
    parameter int NPROC = NPROC_PADRAO,
    parameter int NREGS = NREGS_PADRAO,
    parameter int DW    = DW_PADRAO
) (
    input logic clock,
    input logic reset,
    gerenciador_contexto_if.slave bus
);
    localparam int SW = largura_slot(NPROC);
    localparam int RW = largura_slot(NREGS);
    localparam int IW = RW + 1;
    localparam int AW = SW + RW;

    estado_t       r_estado, w_prox_estado;
    logic [IW-1:0] r_idx, w_prox_idx;
    logic [SW-1:0] r_alvo, r_id_exec;
    logic [NPROC-1:0] r_valido, r_regs_salvos;
    logic [DW-1:0] r_pc_salvo [NPROC];
    logic          r_ativo, r_conc_rapido, r_erro;

    logic [SW-1:0] w_alvo_req;
    logic          w_alvo_valido, w_pedido, w_inicia, w_mesmo, w_fim_salva;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_waddr, w_mem_raddr;
    logic [DW-1:0] w_mem_rdata;
    logic          w_stall, w_rf_we, w_pc_we;
    logic [RW-1:0] w_rf_addr;
    logic [DW-1:0] w_rf_wdata, w_pc_novo;
    logic          w_unused_id;

    assign w_unused_id = ^bus.processo_atual[DW-1:SW];

    // A create in the same cycle makes the target valid for this request (write-first).
    assign w_alvo_req    = bus.processo_atual[SW-1:0];
    assign w_alvo_valido = r_valido[w_alvo_req] |
                           (bus.criar_processo && (bus.id_novo == w_alvo_req));
    assign w_pedido      = (r_estado == IDLE) && bus.troca_contexto;
    assign w_mesmo       = r_ativo && (w_alvo_req == r_id_exec);
    assign w_inicia      = w_pedido && w_alvo_valido && !w_mesmo;
    assign w_fim_salva   = (r_estado == SALVA) && (r_idx == IW'(NREGS - 1));

    always_comb begin
        w_prox_estado = r_estado;
        w_prox_idx    = r_idx;
        w_mem_we      = 1'b0;
        w_mem_waddr   = {r_id_exec, r_idx[RW-1:0]};
        w_mem_raddr   = {r_alvo, r_idx[RW-1:0]};
        w_stall       = 1'b0;
        w_rf_addr     = '0;
        w_rf_we       = 1'b0;
        w_rf_wdata    = '0;
        w_pc_we       = 1'b0;
        w_pc_novo     = '0;
        case (r_estado)
            IDLE: begin
                if (w_inicia) begin
                    w_prox_idx    = '0;
                    w_prox_estado = r_ativo ? SALVA : RESTAURA;
                end
            end
            SALVA: begin
                w_stall   = 1'b1;
                w_rf_addr = r_idx[RW-1:0];
                w_mem_we  = 1'b1;
                if (w_fim_salva) begin
                    w_prox_idx    = '0;
                    w_prox_estado = RESTAURA;
                end else begin
                    w_prox_idx = r_idx + IW'(1);
                end
            end
            RESTAURA: begin
                // Store read data lags the issued address by one cycle.
                w_stall = 1'b1;
                if (r_idx != '0) begin
                    w_rf_we    = 1'b1;
                    w_rf_addr  = RW'(r_idx - IW'(1));
                    w_rf_wdata = r_regs_salvos[r_alvo] ? w_mem_rdata : '0;
                end
                if (r_idx == IW'(NREGS)) begin
                    w_prox_estado = CARREGA_PC;
                end else begin
                    w_prox_idx = r_idx + IW'(1);
                end
            end
            CARREGA_PC: begin
                w_stall       = 1'b1;
                w_pc_we       = 1'b1;
                w_pc_novo     = r_pc_salvo[r_alvo];
                w_prox_estado = CONCLUI;
            end
            CONCLUI: begin
                w_prox_estado = IDLE;
            end
            default: begin
                w_prox_estado = IDLE;
            end
        endcase
    end

    // Creates are applied last so they win over the end-of-save update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado      <= IDLE;
            r_idx         <= '0;
            r_alvo        <= '0;
            r_id_exec     <= '0;
            r_valido      <= '0;
            r_regs_salvos <= '0;
            r_ativo       <= 1'b0;
            r_conc_rapido <= 1'b0;
            r_erro        <= 1'b0;
        end else begin
            r_estado      <= w_prox_estado;
            r_idx         <= w_prox_idx;
            r_erro        <= w_pedido && !w_alvo_valido;
            r_conc_rapido <= w_pedido && w_alvo_valido && w_mesmo;
            if (w_inicia) begin
                r_alvo <= w_alvo_req;
            end
            if (r_estado == CONCLUI) begin
                r_id_exec <= r_alvo;
                r_ativo   <= 1'b1;
            end
            if (w_fim_salva) begin
                r_regs_salvos[r_id_exec] <= 1'b1;
            end
            if (bus.criar_processo) begin
                r_valido[bus.id_novo]      <= 1'b1;
                r_regs_salvos[bus.id_novo] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_inicia && r_ativo) begin
            r_pc_salvo[r_id_exec] <= bus.pc_processo_atual;
        end
        if (bus.criar_processo) begin
            r_pc_salvo[bus.id_novo] <= bus.pc_inicial;
        end
    end

    memoria_contexto #(
        .AW(AW),
        .DW(DW)
    ) u_memoria (
        .clock  (clock),
        .i_we   (w_mem_we),
        .i_waddr(w_mem_waddr),
        .i_wdata(bus.rf_rdata),
        .i_raddr(w_mem_raddr),
        .o_rdata(w_mem_rdata)
    );

    assign bus.cpu_stall       = w_stall;
    assign bus.rf_addr         = w_rf_addr;
    assign bus.rf_we           = w_rf_we;
    assign bus.rf_wdata        = w_rf_wdata;
    assign bus.pc_we           = w_pc_we;
    assign bus.pc_novo         = w_pc_novo;
    assign bus.troca_concluida = (r_estado == CONCLUI) || r_conc_rapido;
    assign bus.erro_processo   = r_erro;
    assign bus.id_executando   = r_id_exec;

endmodule

// File: tb/tb_gerenciador_contexto.sv
// Self-checking bench for gerenciador_contexto: a CPU register file/PC stand-in
// plus a process-table reference model predicting every switch outcome.
module tb_gerenciador_contexto;
    import gerenciador_contexto_pkg::*;

    localparam int NPROC  = 8;
    localparam int NREGS  = 32;
    localparam int DW     = 32;
    localparam int JANELA = 80;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   nFora = 0;

    logic [DW-1:0] cpuRf [NREGS];
    logic [DW-1:0] cpuPc;
    logic          tbWe   = 1'b0;
    logic [4:0]    tbAddr = '0;
    logic [DW-1:0] tbData = '0;

    logic          mValido [NPROC];
    logic          mSalvo  [NPROC];
    logic [DW-1:0] mPc     [NPROC];
    logic [DW-1:0] mCtx    [NPROC][NREGS];
    logic [DW-1:0] regEsperado [NREGS];
    logic          mAtivo;
    logic [2:0]    mExec;

    gerenciador_contexto_if #(.NPROC(NPROC), .NREGS(NREGS), .DW(DW)) bus ();

    gerenciador_contexto #(.NPROC(NPROC), .NREGS(NREGS), .DW(DW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    assign bus.rf_rdata = cpuRf[bus.rf_addr];

    // CPU stand-in: register file and PC, loadable by the DUT or by the bench
    always @(posedge clock) begin
        if (bus.rf_we) begin
            cpuRf[bus.rf_addr] <= bus.rf_wdata;
        end else if (tbWe) begin
            cpuRf[tbAddr] <= tbData;
        end
        if (bus.pc_we) begin
            cpuPc <= bus.pc_novo;
        end
    end

    task automatic modelo_reset();
        for (int s = 0; s < NPROC; s++) begin
            mValido[s] = 1'b0;
            mSalvo[s]  = 1'b0;
        end
        mAtivo = 1'b0;
        mExec  = '0;
    endtask

    task automatic criar(input int slot, input logic [DW-1:0] pc);
        bus.criar_processo = 1'b1;
        bus.id_novo        = 3'(slot);
        bus.pc_inicial     = pc;
        mValido[slot] = 1'b1;
        mSalvo[slot]  = 1'b0;
        mPc[slot]     = pc;
        @(negedge clock);
        bus.criar_processo = 1'b0;
    endtask

    task automatic carrega_regs(input logic [DW-1:0] base, input bit aleatorio);
        for (int i = 0; i < NREGS; i++) begin
            tbWe   = 1'b1;
            tbAddr = 5'(i);
            tbData = aleatorio ? DW'($urandom) : base + DW'(i);
            regEsperado[i] = tbData;
            @(negedge clock);
        end
        tbWe = 1'b0;
    endtask

    task automatic applyStimulus(input int tgt, input logic [DW-1:0] pcOut,
                                 input int cicloExtra, input int tgtExtra,
                                 output int ofs, output int nStall, output int nWe,
                                 output int nErro, output int nConc);
        ofs = -1; nStall = 0; nWe = 0; nErro = 0; nConc = 0;
        bus.troca_contexto    = 1'b1;
        bus.processo_atual    = DW'(tgt);
        bus.pc_processo_atual = pcOut;
        @(posedge clock);
        for (int c = 0; c < JANELA; c++) begin
            @(negedge clock);
            if (bus.cpu_stall)     nStall++;
            if (bus.rf_we)         nWe++;
            if (bus.erro_processo) nErro++;
            if (bus.troca_concluida) begin
                nConc++;
                if (ofs < 0) ofs = c;
            end
            if ((bus.rf_we || bus.pc_we) && !bus.cpu_stall) nFora++;
            bus.criar_processo = 1'b0;
            bus.troca_contexto = (c == cicloExtra);
            if (c == cicloExtra) bus.processo_atual = DW'(tgtExtra);
        end
        bus.troca_contexto = 1'b0;
    endtask

    task automatic test_reset();
        logic [3*DW+8:0] saidas;
        repeat (3) @(negedge clock);
        saidas = {bus.cpu_stall, bus.rf_addr, bus.rf_we, bus.rf_wdata, bus.pc_we,
                  bus.pc_novo, bus.troca_concluida, bus.erro_processo, bus.id_executando};
        total++;
        if (saidas !== '0) begin
            bad++;
            $display("[TB] FAIL reset_held outputs: got %h expected 0", saidas);
        end
        reset = 1'b0;
        @(negedge clock);
        saidas = {bus.cpu_stall, bus.rf_addr, bus.rf_we, bus.rf_wdata, bus.pc_we,
                  bus.pc_novo, bus.troca_concluida, bus.erro_processo, bus.id_executando};
        total++;
        if (saidas !== '0) begin
            bad++;
            $display("[TB] FAIL reset_released outputs: got %h expected 0", saidas);
        end
    endtask

    // Outcome of a request follows from the table alone: invalid, already running, or a real switch
    task automatic test_switch(input int tgt, input logic [DW-1:0] pcOut);
        int tipo, expStall, expOfs, expWe, expErro, expConc;
        int ofs, nStall, nWe, nErro, nConc;
        logic [DW-1:0] expPc;
        expPc = '0;
        if (!mValido[tgt])                     tipo = 0;
        else if (mAtivo && (tgt == int'(mExec))) tipo = 1;
        else                                   tipo = 2;
        expStall = 0; expOfs = -1; expWe = 0; expErro = 0; expConc = 0;
        if (tipo == 0) begin
            expErro = 1;
        end else if (tipo == 1) begin
            expOfs = 0; expConc = 1;
        end else begin
            expStall = mAtivo ? (2 * NREGS + 2) : (NREGS + 2);
            expOfs   = expStall;
            expWe    = NREGS;
            expConc  = 1;
            if (mAtivo) begin
                for (int i = 0; i < NREGS; i++) mCtx[mExec][i] = regEsperado[i];
                mSalvo[mExec] = 1'b1;
                mPc[mExec]    = pcOut;
            end
            for (int i = 0; i < NREGS; i++) regEsperado[i] = mSalvo[tgt] ? mCtx[tgt][i] : '0;
            expPc  = mPc[tgt];
            mExec  = 3'(tgt);
            mAtivo = 1'b1;
        end
        applyStimulus(tgt, pcOut, -1, 0, ofs, nStall, nWe, nErro, nConc);
        total++;
        if (ofs !== expOfs) begin
            bad++;
            $display("[TB] FAIL conclui_offset slot=%0d: got %0d expected %0d", tgt, ofs, expOfs);
        end
        total++;
        if (nStall !== expStall) begin
            bad++;
            $display("[TB] FAIL stall_cycles slot=%0d: got %0d expected %0d", tgt, nStall, expStall);
        end
        total++;
        if (nWe !== expWe) begin
            bad++;
            $display("[TB] FAIL rf_we_count slot=%0d: got %0d expected %0d", tgt, nWe, expWe);
        end
        total++;
        if (nErro !== expErro) begin
            bad++;
            $display("[TB] FAIL erro_pulses slot=%0d: got %0d expected %0d", tgt, nErro, expErro);
        end
        total++;
        if (nConc !== expConc) begin
            bad++;
            $display("[TB] FAIL conclui_pulses slot=%0d: got %0d expected %0d", tgt, nConc, expConc);
        end
        total++;
        if (bus.id_executando !== mExec) begin
            bad++;
            $display("[TB] FAIL id_executando slot=%0d: got %0d expected %0d", tgt, bus.id_executando, mExec);
        end
        if (tipo == 2) begin
            total++;
            if (cpuPc !== expPc) begin
                bad++;
                $display("[TB] FAIL pc_novo slot=%0d: got %h expected %h", tgt, cpuPc, expPc);
            end
            for (int i = 0; i < NREGS; i++) begin
                total++;
                if (cpuRf[i] !== regEsperado[i]) begin
                    bad++;
                    $display("[TB] FAIL restored_reg slot=%0d r%0d: got %h expected %h", tgt, i, cpuRf[i], regEsperado[i]);
                end
            end
        end
    endtask

    task automatic test_ignored_request();
        int ofs, nStall, nWe, nErro, nConc, tgt;
        logic [DW-1:0] pcOut, expPc;
        tgt   = (mExec == 3'd1) ? 0 : 1;
        pcOut = DW'($urandom);
        for (int i = 0; i < NREGS; i++) mCtx[mExec][i] = regEsperado[i];
        mSalvo[mExec] = 1'b1;
        mPc[mExec]    = pcOut;
        for (int i = 0; i < NREGS; i++) regEsperado[i] = mSalvo[tgt] ? mCtx[tgt][i] : '0;
        expPc = mPc[tgt];
        applyStimulus(tgt, pcOut, 5, int'(mExec), ofs, nStall, nWe, nErro, nConc);
        mExec = 3'(tgt);
        total++;
        if (nConc !== 1) begin
            bad++;
            $display("[TB] FAIL ignored_conclui_pulses: got %0d expected 1", nConc);
        end
        total++;
        if (nStall !== 2 * NREGS + 2) begin
            bad++;
            $display("[TB] FAIL ignored_stall_cycles: got %0d expected %0d", nStall, 2 * NREGS + 2);
        end
        total++;
        if (cpuPc !== expPc) begin
            bad++;
            $display("[TB] FAIL ignored_pc_novo: got %h expected %h", cpuPc, expPc);
        end
        total++;
        if (bus.id_executando !== mExec) begin
            bad++;
            $display("[TB] FAIL ignored_id_executando: got %0d expected %0d", bus.id_executando, mExec);
        end
    endtask

    task automatic test_create_collision();
        bus.criar_processo = 1'b1;
        bus.id_novo        = 3'd6;
        bus.pc_inicial     = 32'h600;
        mValido[6] = 1'b1;
        mSalvo[6]  = 1'b0;
        mPc[6]     = 32'h600;
        test_switch(6, 32'h1234);
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                criar(int'($urandom_range(0, 7)), DW'($urandom));
            end else begin
                if ($urandom_range(0, 1) == 1) carrega_regs('0, 1'b1);
                test_switch(int'($urandom_range(0, 7)), DW'($urandom));
            end
        end
    endtask

    task automatic checkOutput();
        total++;
        if (nFora !== 0) begin
            bad++;
            $display("[TB] FAIL we_outside_stall: got %0d expected 0", nFora);
        end
    endtask

    task automatic test_reset_mid();
        int tgt;
        logic [3*DW+8:0] saidas;
        tgt = (mExec == 3'd7) ? 6 : 7;
        criar(tgt, 32'h700);
        bus.troca_contexto = 1'b1;
        bus.processo_atual = DW'(tgt);
        @(posedge clock);
        for (int c = 0; c <= 2 * NREGS + 10 - NREGS + NREGS - NREGS + 10 - 10; c++) begin
            @(negedge clock);
            bus.troca_contexto = 1'b0;
        end
        total++;
        if (bus.rf_we !== 1'b1 || bus.cpu_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_restore_active: got we=%b stall=%b expected 1 1", bus.rf_we, bus.cpu_stall);
        end
        reset = 1'b1;
        #1;
        saidas = {bus.cpu_stall, bus.rf_addr, bus.rf_we, bus.rf_wdata, bus.pc_we,
                  bus.pc_novo, bus.troca_concluida, bus.erro_processo, bus.id_executando};
        total++;
        if (saidas !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid outputs: got %h expected 0", saidas);
        end
        @(negedge clock);
        reset = 1'b0;
        modelo_reset();
        @(negedge clock);
        test_switch(0, 32'h55);
        criar(2, 32'h2A0);
        test_switch(2, 32'h0);
    endtask

    initial begin
        bus.troca_contexto    = 1'b0;
        bus.processo_atual    = '0;
        bus.pc_processo_atual = '0;
        bus.criar_processo    = 1'b0;
        bus.id_novo           = '0;
        bus.pc_inicial        = '0;
        modelo_reset();
        for (int i = 0; i < NREGS; i++) regEsperado[i] = '0;
        test_reset();
        criar(0, 32'h100);
        criar(1, 32'h200);
        test_switch(0, 32'h0);
        carrega_regs(32'hA0, 1'b0);
        test_switch(1, 32'h148);
        carrega_regs('0, 1'b1);
        test_switch(0, 32'h2468);
        test_switch(5, 32'h0);
        test_switch(0, 32'h0);
        test_ignored_request();
        test_create_collision();
        test_random();
        checkOutput();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
